// File: rtl/vdp_cpu_port.sv
`timescale 1ns/1ps
// vdp_cpu_port: CPU access port in front of the VDP core. Turns one-cycle
// CPU strobes on a data/control port pair into VRAM write/read requests,
// register-write pulses and an auto-incrementing VRAM pointer. The CPU is
// stalled through cpuWait for as long as a transfer is outstanding.
//
// VRAM handshake: vramReq is the valid, vramGrant is the ready. A transfer
// completes on the rising edge where both are high. While vramReq is high
// and vramGrant is low, vramReq, vramWe, vramAddr and vramDataOut hold
// steady. For reads, vramDataIn is sampled in the cycle after the grant.
module vdp_cpu_port #(
  parameter int RamBits = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpuSel,
  input  logic               cpuWr,
  input  logic               cpuRd,
  input  logic               cpuPort,
  input  logic [7:0]         cpuDataIn,
  output logic [7:0]         cpuDataOut,
  output logic               cpuWait,
  output logic               vramReq,
  output logic               vramWe,
  output logic [RamBits-1:0] vramAddr,
  output logic [7:0]         vramDataOut,
  input  logic               vramGrant,
  input  logic [7:0]         vramDataIn,
  output logic               regWe,
  output logic [2:0]         regIdx,
  output logic [7:0]         regData,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_REQ  = 2'd1,
    S_RD_REQ  = 2'd2,
    S_RD_DATA = 2'd3
  } state_t;

  state_t             r_state;
  logic [RamBits-1:0] r_ptr;
  logic [7:0]         r_latch;
  logic               r_phase;
  logic               r_mode;
  logic [7:0]         r_buf;
  logic [7:0]         r_read_ahead;
  logic [7:0]         r_cpu_data_out;
  logic               r_vram_req;
  logic               r_vram_we;
  logic               r_reg_we;
  logic [2:0]         r_reg_idx;
  logic [7:0]         r_reg_data;

  logic               w_accept;
  logic               w_busy;
  logic [RamBits-1:0] w_ptr_inc;
  logic [RamBits-9:0] w_latch_hi;

  // A strobe is taken only in IDLE, with exactly one of write/read asserted.
  assign w_accept   = cpuSel && (cpuWr ^ cpuRd) && (r_state == S_IDLE);
  // A pending buffered write is what the status register reports as busy.
  assign w_busy     = r_vram_req && r_vram_we;
  assign w_ptr_inc  = r_ptr + RamBits'(1);
  assign w_latch_hi = r_latch[RamBits-9:0];

  // Port FSM: CPU decode in IDLE, VRAM request/grant sequencing elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_latch        <= '0;
      r_phase        <= 1'b0;
      r_mode         <= 1'b0;
      r_buf          <= '0;
      r_read_ahead   <= '0;
      r_cpu_data_out <= '0;
      r_vram_req     <= 1'b0;
      r_vram_we      <= 1'b0;
      r_reg_we       <= 1'b0;
      r_reg_idx      <= '0;
      r_reg_data     <= '0;
    end else begin
      r_reg_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (cpuWr && cpuPort) begin
              if (!r_phase) begin
                r_latch <= cpuDataIn;
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                case (cpuDataIn[7:6])
                  2'b00: r_ptr[7:0] <= r_latch;
                  2'b01: begin
                    r_ptr[RamBits-1:8] <= w_latch_hi;
                    r_mode             <= 1'b1;
                  end
                  2'b10: begin
                    r_reg_we   <= 1'b1;
                    r_reg_idx  <= cpuDataIn[2:0];
                    r_reg_data <= r_latch;
                  end
                  default: begin
                    // Read setup: prefetch the first byte into readAhead.
                    r_ptr[RamBits-1:8] <= w_latch_hi;
                    r_mode             <= 1'b0;
                    r_state            <= S_RD_REQ;
                    r_vram_req         <= 1'b1;
                    r_vram_we          <= 1'b0;
                  end
                endcase
              end
            end else if (cpuWr) begin
              // Data writes go out whatever the current mode is.
              r_buf      <= cpuDataIn;
              r_phase    <= 1'b0;
              r_state    <= S_WR_REQ;
              r_vram_req <= 1'b1;
              r_vram_we  <= 1'b1;
            end else if (cpuPort) begin
              r_cpu_data_out <= {w_busy, r_mode, r_phase, 5'b00000};
              r_phase        <= 1'b0;
            end else begin
              // Hand back the prefetched byte, then refill from ptr.
              r_cpu_data_out <= r_read_ahead;
              r_phase        <= 1'b0;
              r_state        <= S_RD_REQ;
              r_vram_req     <= 1'b1;
              r_vram_we      <= 1'b0;
            end
          end
        end
        S_WR_REQ: begin
          if (vramGrant) begin
            r_ptr      <= w_ptr_inc;
            r_state    <= S_IDLE;
            r_vram_req <= 1'b0;
            r_vram_we  <= 1'b0;
          end
        end
        S_RD_REQ: begin
          if (vramGrant) begin
            r_ptr      <= w_ptr_inc;
            r_state    <= S_RD_DATA;
            r_vram_req <= 1'b0;
            r_vram_we  <= 1'b0;
          end
        end
        default: begin
          r_read_ahead <= vramDataIn;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign cpuWait     = (r_state != S_IDLE);
  assign cpuDataOut  = r_cpu_data_out;
  assign vramReq     = r_vram_req;
  assign vramWe      = r_vram_we;
  assign vramAddr    = r_ptr;
  assign vramDataOut = r_buf;
  assign regWe       = r_reg_we;
  assign regIdx      = r_reg_idx;
  assign regData     = r_reg_data;
  assign o_dbg_state = r_state;

endmodule

// File: doc/vdp_cpu_port.md
# vdp_cpu_port

CPU-facing access port that sits directly upstream of the VDP core. It converts single-cycle CPU strobes on a two-port interface (data and control) into VRAM write and read requests, register-write pulses and an auto-incrementing VRAM address pointer. VRAM requests are arbitrated against display fetch: the VDP grants a slot only when display fetch is idle, and this block waits for that grant. The CPU is stalled through `cpuWait` while a transfer is outstanding.

## Interface
- `RamBits`, 16, VRAM address width (64 KB default); valid range 9..16.
- `clk` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpuSel` in 1: port selected; strobes are ignored when low.
- `cpuWr` in 1: write strobe, one cycle.
- `cpuRd` in 1: read strobe, one cycle.
- `cpuPort` in 1: 0 = data port, 1 = control port.
- `cpuDataIn` in 8: CPU write data.
- `cpuDataOut` out 8: CPU read data, registered.
- `cpuWait` out 1: stall; high whenever state ≠ IDLE (combinational from state).
- `vramReq` out 1: VRAM transfer request.
- `vramWe` out 1: 1 = write, 0 = read; valid while `vramReq` is high.
- `vramAddr` out RamBits: transfer address.
- `vramDataOut` out 8: write data.
- `vramGrant` in 1: the VDP accepts a request in this cycle.
- `vramDataIn` in 8: read data, valid one cycle after the grant cycle.
- `regWe` out 1: one-cycle register write pulse.
- `regIdx` out 3: register index.
- `regData` out 8: register value.

## Operation
- Access rule: an access is accepted on a rising edge only when `cpuSel` is high, exactly one of `cpuWr`/`cpuRd` is high, and `cpuWait` is low. Strobes during wait are ignored; the CPU must hold them.
- Internal state: pointer `ptr[RamBits-1:0]`, `latch[7:0]`, `phase` (0/1), `mode` (0 = read, 1 = write), `buf[7:0]`, `readAhead[7:0]`.
- Control write, `phase` = 0: `latch ← cpuDataIn`, then `phase ← 1`.
- Control write, `phase` = 1: `cmd = cpuDataIn`, then `phase ← 0`. Decode `cmd[7:6]`:
  - 00: `ptr[7:0] ← latch`.
  - 01: `ptr[RamBits-1:8] ← latch` (truncated to the pointer width), then `mode ← 1`.
  - 10: register write. Pulse `regWe` for one cycle with `regIdx = cmd[2:0]` and `regData = latch`.
  - 11: `ptr[RamBits-1:8] ← latch`, then `mode ← 0`, then start a prefetch (go to RD_REQ).
- Control read: `cpuDataOut ← {busy, mode, phase, 5'b0}`, where `busy` is 1 if `buf` is still pending. Then `phase ← 0`.
- Data write: `buf ← cpuDataIn`, `phase ← 0`, go to WR_REQ. This happens regardless of `mode`.
- Data read: `cpuDataOut ← readAhead`, `phase ← 0`, go to RD_REQ to refill `readAhead` from `ptr`.
- States:
  - IDLE: `vramReq` = 0.
  - WR_REQ: `vramReq` = 1, `vramWe` = 1, `vramAddr = ptr`, `vramDataOut = buf`. On `vramGrant`: `ptr ← ptr+1`, go to IDLE.
  - RD_REQ: `vramReq` = 1, `vramWe` = 0, `vramAddr = ptr`. On `vramGrant`: `ptr ← ptr+1`, go to RD_DATA.
  - RD_DATA: `readAhead ← vramDataIn`, go to IDLE.
- Pointer arithmetic is modulo 2^RamBits: `ptr` at all-ones increments to 0.
- Without a grant, the request holds indefinitely with stable address and data.

## Timing
- Reset (`reset` low, asynchronous): all outputs 0. `ptr`, `latch`, `buf` and `readAhead` are 0. `phase` = 0, `mode` = 0, state = IDLE.
  - Reset mid-transfer abandons the request; `vramReq` drops immediately.
- A data write with the grant held high: the write is accepted at edge N, `vramReq` is high in cycle N+1, the VRAM write occurs at edge N+1, and `cpuWait` is low again in cycle N+2.
- A read refill with the grant held high: RD_REQ in cycle N+1, RD_DATA in N+2, `readAhead` updated at edge N+2, `cpuWait` low in N+3.
- `regWe` is high for exactly the one cycle after the second control write, and is never asserted otherwise.
- `cpuDataOut` updates at the accepting edge and holds until the next accepted read.
- A CPU strobe arriving in the same cycle as the grant is ignored, because `cpuWait` is still high in that cycle.

## Test plan
- Reset, then control writes 0x34/0x00, 0x12/0x40, data writes 0xAA, 0xBB with the grant held high → VRAM writes 0xAA@0x1234 and 0xBB@0x1235; `cpuWait` is high for exactly 1 cycle per write.
- Control writes 0x05/0x83 → `regWe` pulses once with `regIdx` = 3 and `regData` = 0x05; `ptr` and `mode` are unchanged.
- With VRAM holding 0x11@0x2000 and 0x22@0x2001: control writes 0x00/0x00, 0x20/0xC0, then two data reads → `cpuDataOut` = 0x11, then 0x22. The final `ptr` = 0x2003, because of the read-ahead.
- `vramGrant` held low for 10 cycles after a data write → `vramReq`, `vramAddr` and `vramDataOut` stay stable, and `cpuWait` stays high. A CPU write issued meanwhile is not accepted until the grant arrives and the block returns to IDLE.
- `ptr` = 0xFFFF, data write 0x77 → written at 0xFFFF; the next write lands at 0x0000.
- One control write (0x12), then a control (status) read → status bit5 = 1, then `phase` resets. The next control write is treated as a first byte.
